// File: rtl/operand_fetch_stage_pkg.sv
// rtl/operand_fetch_stage_pkg.sv - shared core types and constants for operand fetch
package operand_fetch_stage_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_WB,
        FWD_MEM,
        FWD_EX
    } fwd_sel_t;

endpackage

// File: rtl/operand_fetch_stage_bypass_mux.sv
// rtl/operand_fetch_stage_bypass_mux.sv - per-operand bypass select and hazard detect
// Bypass network present only when OPERAND_FORWARDING_EN is defined.
module operand_bypass_mux #(
    parameter int XLEN = operand_fetch_stage_pkg::XLEN
) (
    input  logic [4:0]      rs,
    input  logic            use_rs,
    input  logic [XLEN-1:0] rf_data,
    input  logic [4:0]      ex_rd,
    input  logic [4:0]      mem_rd,
    input  logic [4:0]      wb_rd,
    input  logic            ex_regwrite,
    input  logic            mem_regwrite,
    input  logic            wb_regwrite,
    input  logic            ex_is_load,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] mem_result,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] value,
    output logic            hazard
);
    import operand_fetch_stage_pkg::*;

    logic     src_live;
    logic     match_ex;
    logic     match_mem;
    logic     match_wb;
    fwd_sel_t sel;

    assign src_live  = use_rs && (rs != REG_X0);
    assign match_ex  = src_live && ex_regwrite  && (ex_rd  == rs);
    assign match_mem = src_live && mem_regwrite && (mem_rd == rs);
    assign match_wb  = src_live && wb_regwrite  && (wb_rd  == rs);

`ifdef OPERAND_FORWARDING_EN
    always_comb begin
        sel = FWD_RF;
        if (match_ex)
            sel = FWD_EX;
        else if (match_mem)
            sel = FWD_MEM;
        else if (match_wb)
            sel = FWD_WB;
    end

    // Only a load in EX lacks its result in time; everything else can bypass.
    assign hazard = match_ex && ex_is_load;

    always_comb begin
        value = rf_data;
        if (rs == REG_X0)
            value = '0;
        else begin
            case (sel)
                FWD_EX:  value = ex_result;
                FWD_MEM: value = mem_result;
                FWD_WB:  value = wb_data;
                default: value = rf_data;
            endcase
        end
    end
`else
    logic unused_fwd;

    assign sel        = FWD_RF;
    assign hazard     = match_ex || match_mem || match_wb;
    assign unused_fwd = ^{ex_is_load, ex_result, mem_result, wb_data, sel};

    always_comb begin
        value = rf_data;
        if (rs == REG_X0)
            value = '0;
    end
`endif

endmodule

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - operand fetch, hazard resolution and ID/EX register
// Bypassing is enabled by defining OPERAND_FORWARDING_EN.
module operand_fetch_stage #(
    parameter int XLEN   = operand_fetch_stage_pkg::XLEN,
    parameter int CTRL_W = operand_fetch_stage_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic [4:0]        rf_rs1_addr,
    output logic [4:0]        rf_rs2_addr,
    input  logic [XLEN-1:0]   rf_rs1_data,
    input  logic [XLEN-1:0]   rf_rs2_data,
    input  logic [4:0]        ex_rd,
    input  logic [4:0]        mem_rd,
    input  logic [4:0]        wb_rd,
    input  logic              ex_regwrite,
    input  logic              mem_regwrite,
    input  logic              wb_regwrite,
    input  logic              ex_is_load,
    input  logic [XLEN-1:0]   ex_result,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_op1,
    output logic [XLEN-1:0]   out_op2,
    output logic [4:0]        out_rd,
    output logic [CTRL_W-1:0] out_ctrl
);
    import operand_fetch_stage_pkg::*;

    logic            advance;
    logic            hazard_stall;
    logic            hazard1;
    logic            hazard2;
    logic            load;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    assign rf_rs1_addr = in_rs1;
    assign rf_rs2_addr = in_rs2;

    operand_bypass_mux #(.XLEN(XLEN)) u_mux_rs1 (
        .rs(in_rs1), .use_rs(in_use_rs1), .rf_data(rf_rs1_data),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .ex_is_load(ex_is_load), .ex_result(ex_result), .mem_result(mem_result),
        .wb_data(wb_data), .value(op1), .hazard(hazard1)
    );

    operand_bypass_mux #(.XLEN(XLEN)) u_mux_rs2 (
        .rs(in_rs2), .use_rs(in_use_rs2), .rf_data(rf_rs2_data),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .ex_is_load(ex_is_load), .ex_result(ex_result), .mem_result(mem_result),
        .wb_data(wb_data), .value(op2), .hazard(hazard2)
    );

    assign advance      = !out_valid || out_ready;
    assign hazard_stall = hazard1 || hazard2;
    // A flush swallows the incoming instruction, so it is always "accepted".
    assign in_ready     = flush || (advance && !hazard_stall);
    assign load         = advance && in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_imm   <= '0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_rd    <= '0;
            out_ctrl  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (advance) begin
            out_valid <= load;
            if (load) begin
                out_pc   <= in_pc;
                out_imm  <= in_imm;
                out_op1  <= op1;
                out_op2  <= op2;
                out_rd   <= in_rd;
                out_ctrl <= in_ctrl;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - directed self-checking bench for operand_fetch_stage
module tb_operand_fetch_stage;
    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [XLEN-1:0]   in_imm;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [4:0]        in_rd;
    logic              in_use_rs1;
    logic              in_use_rs2;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic [4:0]        rf_rs1_addr;
    logic [4:0]        rf_rs2_addr;
    logic [XLEN-1:0]   rf_rs1_data;
    logic [XLEN-1:0]   rf_rs2_data;
    logic [4:0]        ex_rd;
    logic [4:0]        mem_rd;
    logic [4:0]        wb_rd;
    logic              ex_regwrite;
    logic              mem_regwrite;
    logic              wb_regwrite;
    logic              ex_is_load;
    logic [XLEN-1:0]   ex_result;
    logic [XLEN-1:0]   mem_result;
    logic [XLEN-1:0]   wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_imm;
    logic [XLEN-1:0]   out_op1;
    logic [XLEN-1:0]   out_op2;
    logic [4:0]        out_rd;
    logic [CTRL_W-1:0] out_ctrl;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] regs [32];

    assign rf_rs1_data = regs[rf_rs1_addr];
    assign rf_rs2_data = regs[rf_rs2_addr];

    always #5 clk = ~clk;

    operand_fetch_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_ctrl(in_ctrl), .flush(flush),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .ex_is_load(ex_is_load),
        .ex_result(ex_result), .mem_result(mem_result), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_imm(out_imm),
        .out_op1(out_op1), .out_op2(out_op2),
        .out_rd(out_rd), .out_ctrl(out_ctrl)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        in_valid = 0; in_pc = 0; in_imm = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_use_rs1 = 0; in_use_rs2 = 0; in_ctrl = 0; flush = 0; out_ready = 1;
        ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_regwrite = 0; mem_regwrite = 0; wb_regwrite = 0; ex_is_load = 0;
        ex_result = 0; mem_result = 0; wb_data = 0;
    endtask

    task automatic present(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic u1, input logic u2);
        in_valid = 1; in_pc = pc; in_imm = pc + 32'h1000; in_rs1 = rs1; in_rs2 = rs2;
        in_rd = rd; in_use_rs1 = u1; in_use_rs2 = u2; in_ctrl = pc[15:0] ^ 16'hA5A5;
    endtask

    task automatic test_reset;
        rst = 0;
        clear_inputs();
        present(32'h10, 5'd5, 5'd6, 5'd1, 1, 1);
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", out_pc); end
        checks++; if (out_imm !== 32'h0) begin errors++; $display("FAIL reset_imm got %h exp 0", out_imm); end
        checks++; if (out_op1 !== 32'h0) begin errors++; $display("FAIL reset_op1 got %h exp 0", out_op1); end
        checks++; if (out_op2 !== 32'h0) begin errors++; $display("FAIL reset_op2 got %h exp 0", out_op2); end
        checks++; if (out_rd !== 5'h0) begin errors++; $display("FAIL reset_rd got %h exp 0", out_rd); end
        checks++; if (out_ctrl !== 16'h0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", out_ctrl); end
        rst = 1;
        clear_inputs();
        step();
    endtask

    task automatic test_independent;
        present(32'h100, 5'd5, 5'd6, 5'd1, 1, 1);
        #1;
        checks++; if (rf_rs1_addr !== 5'd5) begin errors++; $display("FAIL rf_addr1 got %h exp 5", rf_rs1_addr); end
        checks++; if (rf_rs2_addr !== 5'd6) begin errors++; $display("FAIL rf_addr2 got %h exp 6", rf_rs2_addr); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL indep_ready got %h exp 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL indep_valid got %h exp 1", out_valid); end
        checks++; if (out_op1 !== 32'd7) begin errors++; $display("FAIL indep_op1 got %h exp 7", out_op1); end
        checks++; if (out_op2 !== 32'd9) begin errors++; $display("FAIL indep_op2 got %h exp 9", out_op2); end
        checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL indep_pc got %h exp 100", out_pc); end
        checks++; if (out_imm !== 32'h1100) begin errors++; $display("FAIL indep_imm got %h exp 1100", out_imm); end
        checks++; if (out_rd !== 5'd1) begin errors++; $display("FAIL indep_rd got %h exp 1", out_rd); end
        checks++; if (out_ctrl !== 16'hA4A5) begin errors++; $display("FAIL indep_ctrl got %h exp a4a5", out_ctrl); end
        present(32'h104, 5'd6, 5'd5, 5'd2, 1, 1);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %h exp 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %h exp 1", out_valid); end
        checks++; if (out_op1 !== 32'd9) begin errors++; $display("FAIL b2b_op1 got %h exp 9", out_op1); end
        checks++; if (out_op2 !== 32'd7) begin errors++; $display("FAIL b2b_op2 got %h exp 7", out_op2); end
        checks++; if (out_pc !== 32'h104) begin errors++; $display("FAIL b2b_pc got %h exp 104", out_pc); end
        clear_inputs();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %h exp 0", out_valid); end
        checks++; if (out_pc !== 32'h104) begin errors++; $display("FAIL idle_pc_hold got %h exp 104", out_pc); end
    endtask

    task automatic test_ex_bypass;
        present(32'h300, 5'd3, 5'd0, 5'd7, 1, 0);
        ex_rd = 3; ex_regwrite = 1; ex_result = 32'h55;
        #1;
`ifdef OPERAND_FORWARDING_EN
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ex_ready got %h exp 1", in_ready); end
        step();
        checks++; if (out_op1 !== 32'h55) begin errors++; $display("FAIL ex_op1 got %h exp 55", out_op1); end
        present(32'h304, 5'd3, 5'd0, 5'd7, 1, 0);
        mem_rd = 3; mem_regwrite = 1; mem_result = 32'h66;
        #1;
        step();
        checks++; if (out_op1 !== 32'h55) begin errors++; $display("FAIL ex_over_mem_op1 got %h exp 55", out_op1); end
        checks++; if (out_pc !== 32'h304) begin errors++; $display("FAIL ex_over_mem_pc got %h exp 304", out_pc); end
`else
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ex_stall_ready got %h exp 0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ex_stall_bubble got %h exp 0", out_valid); end
        ex_regwrite = 0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ex_resume_ready got %h exp 1", in_ready); end
        step();
        checks++; if (out_op1 !== 32'h33) begin errors++; $display("FAIL ex_rf_op1 got %h exp 33", out_op1); end
`endif
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ex_valid got %h exp 1", out_valid); end
        clear_inputs();
    endtask

    task automatic test_load_use;
        present(32'h3FC, 5'd5, 5'd6, 5'd11, 1, 1);
        #1;
        step();
        present(32'h400, 5'd0, 5'd4, 5'd8, 0, 1);
        ex_rd = 4; ex_regwrite = 1; ex_is_load = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_ready got %h exp 0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %h exp 0", out_valid); end
        checks++; if (out_pc !== 32'h3FC) begin errors++; $display("FAIL lu_pc_hold got %h exp 3fc", out_pc); end
        ex_regwrite = 0; ex_is_load = 0;
        mem_rd = 4; mem_regwrite = 1; mem_result = 32'hAB;
        #1;
`ifdef OPERAND_FORWARDING_EN
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_mem_ready got %h exp 1", in_ready); end
        step();
        checks++; if (out_op2 !== 32'hAB) begin errors++; $display("FAIL lu_op2 got %h exp ab", out_op2); end
`else
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_mem_stall got %h exp 0", in_ready); end
        step();
        mem_regwrite = 0;
        #1;
        step();
        checks++; if (out_op2 !== 32'h44) begin errors++; $display("FAIL lu_rf_op2 got %h exp 44", out_op2); end
`endif
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lu_valid got %h exp 1", out_valid); end
        checks++; if (out_op1 !== 32'h0) begin errors++; $display("FAIL lu_op1_x0 got %h exp 0", out_op1); end
        checks++; if (out_pc !== 32'h400) begin errors++; $display("FAIL lu_pc got %h exp 400", out_pc); end
        clear_inputs();
    endtask

    task automatic test_x0;
        present(32'h500, 5'd0, 5'd5, 5'd9, 1, 1);
        ex_rd = 0; ex_regwrite = 1; ex_result = 32'hFF;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %h exp 1", in_ready); end
        step();
        checks++; if (out_op1 !== 32'h0) begin errors++; $display("FAIL x0_op1 got %h exp 0", out_op1); end
        checks++; if (out_op2 !== 32'd7) begin errors++; $display("FAIL x0_op2 got %h exp 7", out_op2); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL x0_valid got %h exp 1", out_valid); end
        clear_inputs();
    endtask

    task automatic test_backpressure_flush;
        present(32'h600, 5'd5, 5'd6, 5'd10, 1, 1);
        #1;
        step();
        out_ready = 0;
        present(32'h604, 5'd4, 5'd0, 5'd12, 1, 0);
        ex_rd = 4; ex_regwrite = 1; ex_is_load = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %h exp 0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %h exp 1", i, out_valid); end
            checks++; if (out_pc !== 32'h600) begin errors++; $display("FAIL bp_pc[%0d] got %h exp 600", i, out_pc); end
            checks++; if (out_op1 !== 32'd7) begin errors++; $display("FAIL bp_op1[%0d] got %h exp 7", i, out_op1); end
        end
        flush = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %h exp 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %h exp 0", out_valid); end
        checks++; if (out_pc !== 32'h600) begin errors++; $display("FAIL flush_pc_hold got %h exp 600", out_pc); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_stall;
        present(32'h700, 5'd5, 5'd6, 5'd13, 1, 1);
        #1;
        step();
        present(32'h704, 5'd4, 5'd0, 5'd14, 1, 0);
        ex_rd = 4; ex_regwrite = 1; ex_is_load = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rms_ready got %h exp 0", in_ready); end
        rst = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rms_async_valid got %h exp 0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rms_async_pc got %h exp 0", out_pc); end
        step();
        rst = 1;
        ex_regwrite = 0; ex_is_load = 0;
        present(32'h704, 5'd4, 5'd0, 5'd14, 1, 0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rms_resume_ready got %h exp 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rms_valid got %h exp 1", out_valid); end
        checks++; if (out_pc !== 32'h704) begin errors++; $display("FAIL rms_pc got %h exp 704", out_pc); end
        checks++; if (out_op1 !== 32'h44) begin errors++; $display("FAIL rms_op1 got %h exp 44", out_op1); end
        clear_inputs();
    endtask

    task automatic test_wb_match;
        present(32'h800, 5'd2, 5'd0, 5'd15, 1, 0);
        wb_rd = 2; wb_regwrite = 1; wb_data = 32'h99;
        #1;
`ifdef OPERAND_FORWARDING_EN
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wb_ready got %h exp 1", in_ready); end
        step();
        checks++; if (out_op1 !== 32'h99) begin errors++; $display("FAIL wb_op1 got %h exp 99", out_op1); end
`else
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL wb_stall_ready got %h exp 0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wb_bubble got %h exp 0", out_valid); end
        wb_regwrite = 0;
        #1;
        step();
        checks++; if (out_op1 !== 32'h22) begin errors++; $display("FAIL wb_rf_op1 got %h exp 22", out_op1); end
`endif
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wb_valid got %h exp 1", out_valid); end
        clear_inputs();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = i * 32'h11;
        regs[0] = 32'hDEAD_BEEF;
        regs[5] = 32'd7;
        regs[6] = 32'd9;
        rst = 0;
        clear_inputs();
        #1;
        test_reset();
        test_independent();
        test_ex_bypass();
        test_load_use();
        test_x0();
        test_backpressure_flush();
        test_reset_mid_stall();
        test_wb_match();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Decode-side operand fetch and ID/EX pipeline register for the pipelined RV32I core. It is the read end of the register file interface. It drives the two register file read addresses and takes back the combinational read data. It resolves RAW hazards against the EX, MEM and WB stages by bypassing or interlocking, then registers the operands, immediate, PC and control bundle toward EX under a valid/ready handshake.

## Interface
- XLEN, 32, datapath width
- CTRL_W, 16, width of opaque decoded control bundle passed through to EX
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- in_valid  in  1  IF/ID holds a decoded instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_pc, in_imm  in  XLEN  PC and sign-extended immediate
- in_rs1, in_rs2, in_rd  in  5  source/destination register addresses
- in_use_rs1, in_use_rs2  in  1  instruction actually reads rs1/rs2
- in_ctrl  in  CTRL_W  control bundle
- flush  in  1  branch/jump redirect: kill current and incoming instruction
- rf_rs1_addr, rf_rs2_addr  out  5  register file read addresses
- rf_rs1_data, rf_rs2_data  in  XLEN  register file read data (combinational)
- ex_rd, mem_rd, wb_rd  in  5  destination of instruction in EX/MEM/WB
- ex_regwrite, mem_regwrite, wb_regwrite  in  1  that stage will write ex_rd/mem_rd/wb_rd
- ex_is_load  in  1  EX instruction is a load (result not yet available)
- ex_result, mem_result, wb_data  in  XLEN  value each stage will write
- out_valid  out  1  ID/EX register holds a valid instruction
- out_ready  in  1  EX accepts this cycle
- out_pc, out_imm, out_op1, out_op2  out  XLEN  registered PC, immediate, resolved operands
- out_rd  out  5  registered destination
- out_ctrl  out  CTRL_W  registered control bundle

## Operation
- rf_rs1_addr = in_rs1 and rf_rs2_addr = in_rs2, combinationally and always.
- Source match: in_use_rsN, in_rsN != 0, and stage regwrite set with stage rd == in_rsN.
- Bypass priority per operand: EX > MEM > WB > register file.
- Address 0 always resolves to 0; x0 is never forwarded.
- Load-use hazard: EX match with ex_is_load forces hazard_stall.
- MEM and WB matches are always forwardable.
- advance = !out_valid || out_ready.
- in_ready = advance && !hazard_stall, or 1 when flush is set.
- On advance with in_valid, in_ready and no flush: load the ID/EX register and set out_valid.
- On advance without a transfer, or with a stall: clear out_valid (bubble). The data fields hold their previous values.
- When !advance: the ID/EX register holds all fields.
- flush: out_valid cleared at the next edge and the incoming instruction is consumed and dropped. flush overrides stall and !advance.

## Timing
- Reset (rst low, asynchronous): out_valid=0; out_pc, out_imm, out_op1, out_op2, out_rd and out_ctrl all 0.
- Latency is 1 cycle from accepted input to out_valid.
- Throughput is 1 instruction per cycle with no hazards.
- A load-use hazard inserts exactly one bubble: the instruction is accepted on the following cycle via the MEM bypass.
- Reset deasserted mid-stall: the stage resumes from the empty state and the held instruction is re-presented by IF/ID.
- Simultaneous out_ready=0 and hazard: the stage holds, with no bubble overwriting the valid entry.

## Configuration
- OPERAND_FORWARDING_EN defined: bypass network as above.
- OPERAND_FORWARDING_EN undefined:
  - No bypass; the register file data is used directly.
  - hazard_stall is asserted on any EX, MEM or WB source match (loads included).
  - Ports are unchanged; ex_result, mem_result and wb_data are ignored.

## Structure
- Shared core package holds:
  - XLEN and CTRL_W defaults
  - REG_X0 constant
  - fwd_sel_t enum {FWD_RF, FWD_WB, FWD_MEM, FWD_EX}
- Sub-module operand_bypass_mux: one per operand; computes fwd_sel_t, the resolved value and the load-use flag from one source address. Instantiated twice.

## Test plan
- Independent stream: addi x1 and addi x2 with regfile x5=7 and x6=9, use_rs1/2 set -> out_op1=7, out_op2=9 one cycle later, no bubbles.
- EX bypass: ex_rd=3, ex_regwrite=1, ex_result=0x55, in_rs1=3 -> out_op1=0x55. With mem_rd=3 and mem_result=0x66 also asserted, EX still wins -> out_op1=0x55.
- Load-use: ex_is_load=1, ex_rd=4, in_rs2=4 -> in_ready=0, one bubble (out_valid=0). The next cycle with mem_rd=4 and mem_result=0xAB -> out_op2=0xAB.
- x0: in_rs1=0 with ex_rd=0, ex_regwrite=1, ex_result=0xFF -> out_op1=0, no stall.
- Backpressure then flush: out_ready=0 for 3 cycles -> outputs stable. Then assert flush -> out_valid=0 next edge and in_ready=1.
- OPERAND_FORWARDING_EN undefined: wb_rd=2 match on in_rs1 -> one stall cycle, then out_op1 = register file value.
